// File: rtl/pe_dot_sequencer.sv
// Dot-product job sequencer for a single always-accumulating MAC lane.
// It clears the lane, streams operand pairs from two synchronous-read buffers, then returns the sum.
module pe_dot_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  output logic                  busy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] a_addr,
  output logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic [DATA_WIDTH-1:0] pe_floatA,
  output logic [DATA_WIDTH-1:0] pe_floatB,
  output logic                  pe_clear,
  input  logic [DATA_WIDTH-1:0] pe_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  typedef enum logic [2:0] {StIdle, StClear, StStream, StDrain, StOutput} state_e;

  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CntOne  = (ADDR_WIDTH + 1)'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [1:0]            drain_q, drain_d;
  logic [ADDR_WIDTH-1:0] base_a_q, base_a_d;
  logic [ADDR_WIDTH-1:0] base_b_q, base_b_d;
  logic                  busy_q, busy_d;
  logic                  rd_en_q, rd_en_d;
  logic                  rd_flag_q, rd_flag_d;
  logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
  logic [ADDR_WIDTH-1:0] b_addr_q, b_addr_d;
  logic [DATA_WIDTH-1:0] pe_a_q, pe_a_d;
  logic [DATA_WIDTH-1:0] pe_b_q, pe_b_d;
  logic                  pe_clear_q, pe_clear_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    base_a_d    = base_a_q;
    base_b_d    = base_b_q;
    rd_en_d     = 1'b0;
    a_addr_d    = a_addr_q;
    b_addr_d    = b_addr_q;
    pe_clear_d  = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    // Buffer data lands one cycle after the strobe; zero operands make the lane hold.
    rd_flag_d   = rd_en_q;
    pe_a_d      = rd_flag_q ? a_data : '0;
    pe_b_d      = rd_flag_q ? b_data : '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StClear;
          len_d      = len;
          base_a_d   = base_a;
          base_b_d   = base_b;
          pe_clear_d = 1'b1;
        end
      end
      StClear: begin
        if (len_q != '0) begin
          state_d  = StStream;
          rd_en_d  = 1'b1;
          a_addr_d = base_a_q;
          b_addr_d = base_b_q;
          cnt_d    = CntOne;
        end else begin
          state_d = StDrain;
          drain_d = 2'd0;
        end
      end
      StStream: begin
        // cnt_q counts reads already issued, including the one on the bus now.
        if (cnt_q == len_q) begin
          state_d = StDrain;
          drain_d = 2'd0;
        end else begin
          rd_en_d  = 1'b1;
          a_addr_d = a_addr_q + AddrOne;
          b_addr_d = b_addr_q + AddrOne;
          cnt_d    = cnt_q + CntOne;
        end
      end
      StDrain: begin
        if (drain_q == 2'd2) begin
          state_d     = StOutput;
          out_valid_d = 1'b1;
          out_data_d  = pe_result;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      StOutput: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      cnt_q       <= '0;
      drain_q     <= 2'd0;
      base_a_q    <= '0;
      base_b_q    <= '0;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_flag_q   <= 1'b0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      pe_a_q      <= '0;
      pe_b_q      <= '0;
      pe_clear_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      base_a_q    <= base_a_d;
      base_b_q    <= base_b_d;
      busy_q      <= busy_d;
      rd_en_q     <= rd_en_d;
      rd_flag_q   <= rd_flag_d;
      a_addr_q    <= a_addr_d;
      b_addr_q    <= b_addr_d;
      pe_a_q      <= pe_a_d;
      pe_b_q      <= pe_b_d;
      pe_clear_q  <= pe_clear_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy      = busy_q;
  assign rd_en     = rd_en_q;
  assign a_addr    = a_addr_q;
  assign b_addr    = b_addr_q;
  assign pe_floatA = pe_a_q;
  assign pe_floatB = pe_b_q;
  assign pe_clear  = pe_clear_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_pe_dot_sequencer.sv
// Directed bench: behavioural MAC lane and two synchronous-read buffers around the sequencer.
module tb_pe_dot_sequencer;

  localparam logic [31:0] F0  = 32'h0000_0000;
  localparam logic [31:0] F1  = 32'h3F80_0000;
  localparam logic [31:0] F2  = 32'h4000_0000;
  localparam logic [31:0] F3  = 32'h4040_0000;
  localparam logic [31:0] F4  = 32'h4080_0000;
  localparam logic [31:0] F5  = 32'h40A0_0000;
  localparam logic [31:0] F6  = 32'h40C0_0000;
  localparam logic [31:0] F8  = 32'h4100_0000;
  localparam logic [31:0] F32 = 32'h4200_0000;
  localparam logic [31:0] F256 = 32'h4380_0000;

  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [8:0]  len;
  logic [7:0]  base_a, base_b;
  logic        busy, rd_en, pe_clear, out_valid;
  logic [7:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data, pe_floatA, pe_floatB, pe_result, out_data;
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] acc;
  logic [7:0]  exp_addr;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pe_dot_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .base_a(base_a), .base_b(base_b),
    .busy(busy), .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr),
    .a_data(a_data), .b_data(b_data), .pe_floatA(pe_floatA), .pe_floatB(pe_floatB),
    .pe_clear(pe_clear), .pe_result(pe_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= mem_a[a_addr];
      b_data <= mem_b[b_addr];
    end
  end

  always @(posedge clk) begin
    if (pe_clear) acc <= 32'd0;
    else          acc <= r2f(f2r(acc) + f2r(pe_floatA) * f2r(pe_floatB));
  end
  assign pe_result = acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; out_ready = 1'b0; len = '0; base_a = '0; base_b = '0;
    a_data = '0; b_data = '0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = F0;
      mem_b[i] = F0;
    end
    cyc(); cyc();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_pe_clear", 32'(pe_clear), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, F0);
    check("rst_a_addr", 32'(a_addr), 32'd0);
    check("rst_pe_floatA", pe_floatA, F0);
    reset = 1'b1;
    cyc();
    check("idle_pe_clear", 32'(pe_clear), 32'd0);

    // len=3: 1*4 + 2*5 + 3*6 = 32
    mem_a[8'h10] = F1; mem_a[8'h11] = F2; mem_a[8'h12] = F3;
    mem_b[8'h20] = F4; mem_b[8'h21] = F5; mem_b[8'h22] = F6;
    base_a = 8'h10; base_b = 8'h20; len = 9'd3; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc(); start = 1'b0;
      check($sformatf("j1_busy_c%0d", c), 32'(busy), 32'd1);
      check($sformatf("j1_rd_en_c%0d", c), 32'(rd_en), 32'(c >= 2 && c <= 4));
      check($sformatf("j1_valid_c%0d", c), 32'(out_valid), 32'(c == 8));
      if (c == 1) check("j1_pe_clear", 32'(pe_clear), 32'd1);
      if (c >= 2 && c <= 4) begin
        check($sformatf("j1_a_addr_c%0d", c), 32'(a_addr), 32'(8'h10 + c - 2));
        check($sformatf("j1_b_addr_c%0d", c), 32'(b_addr), 32'(8'h20 + c - 2));
      end
    end
    check("j1_out_data", out_data, F32);

    // Back-pressure with a start pulse that must be ignored.
    for (int i = 0; i < 4; i++) begin
      start = (i == 1); len = 9'd1;
      cyc();
      check($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_data_%0d", i), out_data, F32);
      check($sformatf("bp_pe_result_%0d", i), pe_result, F32);
    end
    start = 1'b0; out_ready = 1'b1;
    cyc();
    check("hs_valid", 32'(out_valid), 32'd0);
    check("hs_busy", 32'(busy), 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("no_job_busy_%0d", i), 32'(busy), 32'd0);
      check($sformatf("no_job_rd_en_%0d", i), 32'(rd_en), 32'd0);
    end

    // len=0: stale 32.0 in the lane must not leak.
    check("stale_pe", pe_result, F32);
    len = 9'd0; start = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      cyc(); start = 1'b0;
      check($sformatf("j0_rd_en_c%0d", c), 32'(rd_en), 32'd0);
      check($sformatf("j0_valid_c%0d", c), 32'(out_valid), 32'(c == 5));
    end
    check("j0_out_data", out_data, F0);
    cyc();
    check("j0_idle", 32'(busy), 32'd0);

    // Address wrap: a_addr FE, FF, 00, 01; sum 4 * (1*2) = 8
    mem_a[8'hFE] = F1; mem_a[8'hFF] = F1; mem_a[8'h00] = F1; mem_a[8'h01] = F1;
    for (int i = 0; i < 4; i++) mem_b[i] = F2;
    base_a = 8'hFE; base_b = 8'h00; len = 9'd4; start = 1'b1;
    exp_addr = 8'hFE;
    for (int c = 1; c <= 9; c++) begin
      cyc(); start = 1'b0;
      check($sformatf("wr_rd_en_c%0d", c), 32'(rd_en), 32'(c >= 2 && c <= 5));
      check($sformatf("wr_valid_c%0d", c), 32'(out_valid), 32'(c == 9));
      if (c >= 2 && c <= 5) begin
        check($sformatf("wr_a_addr_c%0d", c), 32'(a_addr), 32'(exp_addr));
        exp_addr = exp_addr + 8'd1;
      end
    end
    check("wr_out_data", out_data, F8);
    cyc();
    check("wr_idle", 32'(busy), 32'd0);

    // Reset mid-stream at k=2 of 5, then a fresh 2*3 job.
    out_ready = 1'b0;
    base_a = 8'h30; base_b = 8'h30; len = 9'd5; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc(); start = 1'b0;
    end
    check("mr_a_addr_k2", 32'(a_addr), 32'h32);
    reset = 1'b0;
    cyc();
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_rd_en", 32'(rd_en), 32'd0);
    check("mr_pe_clear", 32'(pe_clear), 32'd1);
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_pe_floatA", pe_floatA, F0);
    reset = 1'b1;
    cyc();
    check("mr_after_busy", 32'(busy), 32'd0);
    check("mr_after_clear", 32'(pe_clear), 32'd0);
    mem_a[8'h40] = F2; mem_b[8'h50] = F3;
    base_a = 8'h40; base_b = 8'h50; len = 9'd1; start = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc(); start = 1'b0;
      check($sformatf("j2_valid_c%0d", c), 32'(out_valid), 32'(c == 6));
    end
    check("j2_out_data", out_data, F6);
    cyc();

    // Full length: 256 pairs of 1.0
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = F1;
      mem_b[i] = F1;
    end
    base_a = 8'h00; base_b = 8'h00; len = 9'd256; start = 1'b1;
    for (int c = 1; c <= 261; c++) begin
      cyc(); start = 1'b0;
      if (c == 257) check("full_rd_en_last", 32'(rd_en), 32'd1);
      if (c == 258) check("full_rd_en_off", 32'(rd_en), 32'd0);
      if (c == 260) check("full_valid_early", 32'(out_valid), 32'd0);
      if (c == 261) check("full_valid", 32'(out_valid), 32'd1);
    end
    check("full_out_data", out_data, F256);
    cyc();
    check("full_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_dot_sequencer.md
# pe_dot_sequencer

Control/datapath sequencer that drives one `ProcessingElement` multiply-accumulate lane from the operand-buffer side. It accepts a dot-product job (two base addresses and a length), clears the PE accumulator, streams operand pairs from two synchronous-read buffers into the PE, drains the PE pipeline, and presents the finished float32 sum on a valid/ready output port. The PE accumulates on every clock, so this block owns the PE's operand inputs and clear line outright.

## Interface
- `DATA_WIDTH`, 32: IEEE-754 word width.
- `ADDR_WIDTH`, 8: operand buffer address width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: job request, sampled only in IDLE.
- `len` in ADDR_WIDTH+1: number of operand pairs, 0..2^ADDR_WIDTH.
- `base_a`, `base_b` in ADDR_WIDTH: first buffer addresses.
- `busy` out 1: high in every state except IDLE.
- `rd_en` out 1: buffer read strobe.
- `a_addr`, `b_addr` out ADDR_WIDTH: buffer read addresses.
- `a_data`, `b_data` in DATA_WIDTH: buffer read data, valid exactly 1 cycle after `rd_en`.
- `pe_floatA`, `pe_floatB` out DATA_WIDTH: to PE operand inputs.
- `pe_clear` out 1: to the PE's active-high clear input.
- `pe_result` in DATA_WIDTH: PE accumulator output.
- `out_valid` out 1, `out_ready` in 1, `out_data` out DATA_WIDTH: result handshake.

## Operation
- All outputs registered. Reset values: `busy`=0, `rd_en`=0, addresses=0, `pe_floatA`=`pe_floatB`=0, `pe_clear`=1, `out_valid`=0, `out_data`=0, state=IDLE.
- States: IDLE, CLEAR, STREAM, DRAIN, OUTPUT.
- IDLE: `start`=1 latches `len`, `base_a`, `base_b` and moves to CLEAR. `pe_clear` is 0 and operands are 0, so the PE holds its value.
- CLEAR (1 cycle): `pe_clear`=1. Next state is STREAM if len>0, else DRAIN.
- STREAM (len cycles, k=0..len-1): `rd_en`=1, `a_addr`=base_a+k and `b_addr`=base_b+k, both mod 2^ADDR_WIDTH (wrap, no error). Then DRAIN.
- Operand path: a registered flag tracks the read issued the previous cycle. When the flag is set, `pe_floatA`/`pe_floatB` are loaded with `a_data`/`b_data`. Otherwise they are loaded with 0x00000000, so the PE adds +0 and holds.
- DRAIN (3 cycles, counter-driven): `rd_en`=0. On the final DRAIN edge, `out_data` is loaded from `pe_result` and `out_valid` is set. Then OUTPUT.
- OUTPUT: `out_valid`=1, and `out_data` is held stable until `out_valid`&&`out_ready`. On that edge, `out_valid` goes to 0 and the state returns to IDLE.
- `start` outside IDLE is ignored. It is not queued.
- Reset low in any state: state returns to IDLE on that edge, the job is discarded, and all outputs take their reset values. `pe_clear`=1 while reset is low, so the PE is zeroed.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycle 1: CLEAR.
- Cycles 2..len+1: STREAM. Read k is issued in cycle 2+k, its data arrives in 3+k, the operands are presented in 4+k, and they are accumulated at the end of 4+k.
- Cycles len+2..len+4: DRAIN. The last operand pair is accumulated at the end of len+3, and `pe_result` is captured at the end of len+4.
- `out_valid` first high in cycle len+5, so start-to-result latency is len+5 cycles. For len=0, `out_valid` is high in cycle 5.
- Back-to-back jobs: the earliest next `start` is sampled the cycle after the handshake.
- Throughput: one operand pair per cycle during STREAM.

## Test plan
- len=3, A={1.0,2.0,3.0}, B={4.0,5.0,6.0} → `out_data`=0x42000000 (32.0) with `out_valid` rising in cycle 8. `rd_en` high cycles 2–4 with addresses base, base+1, base+2.
- len=0 → `rd_en` never asserted, `out_data`=0x00000000, `out_valid` in cycle 5. A nonzero stale PE value before the job must not leak through.
- Back-pressure: hold `out_ready`=0 for 4 cycles in OUTPUT → `out_data`/`out_valid` stable and `pe_result` unchanged (zero operands). Pulse `start` during busy → ignored, no second job.
- Wrap: base_a=0xFE, len=4 → `a_addr` sequence FE, FF, 00, 01.
- Reset low for 1 cycle mid-STREAM (k=2 of 5) → next cycle IDLE, `busy`=0, `rd_en`=0, `pe_clear`=1. A fresh len=1 job with 2.0×3.0 then yields 0x40C00000.
- Full length: len=256, all operands 1.0 → `out_data`=0x43800000 (256.0), `out_valid` in cycle 261.
